// File: rtl/t03_scanline_scheduler_if.sv
// Display fetch port plus the CPU's share of the same memory port.
// The master side is the scanline scheduler; the slave side is memory/CPU.
interface t03_scanline_scheduler_if;
    logic        mem_req;
    logic [10:0] mem_addr;
    logic        mem_ack;
    logic        cpu_req;
    logic        cpu_gnt;

    modport master (
        output mem_req, mem_addr, cpu_gnt,
        input  mem_ack, cpu_req
    );

    modport slave (
        input  mem_req, mem_addr, cpu_gnt,
        output mem_ack, cpu_req
    );
endinterface

// File: rtl/t03_scanline_scheduler.sv
// Scanline scheduler: vertical line counter, sync/active strobes, and a
// per-line prefetch of FETCH_WORDS memory words for the upcoming line.
// The CPU gets the memory port only while no fetch is running or starting.
// Optional build macro T03_FETCH_TIMEOUT_EN: a fetch still running when the
// line ends is abandoned and the sticky underrun flag is raised. Without it
// the fetch runs to completion across the line boundary and underrun is 0.
module t03_scanline_scheduler #(
    parameter logic [10:0] H_ACTIVE    = 11'd160,
    parameter logic [10:0] HS_START    = 11'd176,
    parameter logic [10:0] HS_END      = 11'd191,
    parameter logic [9:0]  V_ACTIVE    = 10'd240,
    parameter logic [9:0]  V_MAX       = 10'd262,
    parameter logic [9:0]  VS_LINE     = 10'd250,
    parameter int          FETCH_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_tc,
    input  logic [10:0] Hcnt,
    output logic [9:0]  Vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        frame_tc,
    output logic        underrun,
    t03_scanline_scheduler_if.master bus
);

    localparam int WORD_W = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FETCH_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [9:0]        line_q;
    logic [9:0]        next_line;
    logic              start;

    // Address of a word within a line's fetch block, wrapped to the 11-bit bus.
    function automatic logic [10:0] addr_of(input logic [9:0] line,
                                            input logic [WORD_W-1:0] w);
        return 11'(line) * 11'(FETCH_WORDS) + 11'(w);
    endfunction

    assign next_line = (Vcnt == V_MAX) ? 10'd0 : Vcnt + 10'd1;
    // Prefetch for the next line begins as horizontal blanking starts.
    assign start     = (state == IDLE) && (Hcnt == H_ACTIVE) && (next_line < V_ACTIVE);

    assign hsync  = (Hcnt >= HS_START) && (Hcnt <= HS_END);
    assign vsync  = (Vcnt == VS_LINE);
    assign active = (Hcnt < H_ACTIVE) && (Vcnt < V_ACTIVE);

    // A starting fetch takes the port even if the CPU is asking that cycle.
    assign bus.cpu_gnt = bus.cpu_req && (state == IDLE) && !start;

    // Line counter and the one-cycle frame-complete pulse on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Vcnt     <= 10'd0;
            frame_tc <= 1'b0;
        end else begin
            frame_tc <= h_tc && (Vcnt == V_MAX);
            if (h_tc)
                Vcnt <= next_line;
        end
    end

`ifdef T03_FETCH_TIMEOUT_EN
    logic underrun_q;
    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    // Fetch FSM; mem_req/mem_addr are registered and only move on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            word         <= '0;
            line_q       <= 10'd0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= 11'd0;
`ifdef T03_FETCH_TIMEOUT_EN
            underrun_q   <= 1'b0;
`endif
        end else begin
`ifdef T03_FETCH_TIMEOUT_EN
            // Line ended before the fetch retired: abandon it and flag it.
            if (h_tc && (state != IDLE)) begin
                state       <= IDLE;
                bus.mem_req <= 1'b0;
                underrun_q  <= 1'b1;
            end else begin
`else
            begin
`endif
                case (state)
                    IDLE: begin
                        if (start) begin
                            state        <= REQ;
                            word         <= '0;
                            line_q       <= next_line;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= addr_of(next_line, '0);
                        end
                    end
                    REQ: begin
                        if (bus.mem_ack) begin
                            if (word == LAST_WORD) begin
                                state       <= DONE;
                                bus.mem_req <= 1'b0;
                            end else begin
                                word         <= word + WORD_W'(1);
                                bus.mem_addr <= addr_of(line_q, word + WORD_W'(1));
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t03_scanline_scheduler.sv
// Bench for t03_scanline_scheduler: reset-time vector table, hand sequences
// for fetch/arbitration/reset corners, and randomized frames checked every
// cycle against a queue-based reference model.
module tb_t03_scanline_scheduler;

    localparam int H_ACT = 160, HS_S = 176, HS_E = 191;
    localparam int V_ACT = 240, V_MX = 262, VS_L = 250, FW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_tc = 1'b0;
    logic [10:0] Hcnt = 11'd0;
    logic [9:0]  Vcnt;
    logic        hsync, vsync, active, frame_tc, underrun;

    t03_scanline_scheduler_if bus();

    t03_scanline_scheduler dut (
        .clk(clk), .rst(rst), .h_tc(h_tc), .Hcnt(Hcnt), .Vcnt(Vcnt),
        .hsync(hsync), .vsync(vsync), .active(active), .frame_tc(frame_tc),
        .underrun(underrun), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: current line, frame pulse, queue of words still owed
    // by the running fetch, and a one-cycle tail after the last word.
    int m_v;
    bit m_frame, m_tail, m_under;
    int exp_q[$];

    logic        req_at  [0:255];
    logic        gnt_at  [0:255];
    logic [10:0] addr_at [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (exp_q.size() != 0) || m_tail;
    endfunction

    function automatic int m_nl();
        return (m_v == V_MX) ? 0 : m_v + 1;
    endfunction

    task automatic model_reset();
        m_v = 0; m_frame = 0; m_tail = 0; m_under = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int nl;
        bit st, tmo;
        nl  = m_nl();
        st  = !m_busy() && (int'(Hcnt) == H_ACT) && (nl < V_ACT);
        tmo = 1'b0;
`ifdef T03_FETCH_TIMEOUT_EN
        tmo = h_tc && m_busy();
`endif
        if (tmo) begin
            exp_q.delete(); m_tail = 0; m_under = 1;
        end else if (m_tail) begin
            m_tail = 0;
        end else if (exp_q.size() != 0 && bus.mem_ack) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_tail = 1;
        end
        if (st)
            for (int i = 0; i < FW; i++) exp_q.push_back((nl * FW + i) % 2048);
        m_frame = h_tc && (m_v == V_MX);
        if (h_tc) m_v = nl;
    endtask

    task automatic compare();
        int  nl = m_nl();
        bit  st = (int'(Hcnt) == H_ACT) && (nl < V_ACT);
        chk("Vcnt", 32'(Vcnt), m_v);
        chk("frame_tc", 32'(frame_tc), 32'(m_frame));
        chk("hsync", 32'(hsync), 32'(int'(Hcnt) >= HS_S && int'(Hcnt) <= HS_E));
        chk("vsync", 32'(vsync), 32'(m_v == VS_L));
        chk("active", 32'(active), 32'(int'(Hcnt) < H_ACT && m_v < V_ACT));
        chk("mem_req", 32'(bus.mem_req), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("mem_addr", 32'(bus.mem_addr), exp_q[0]);
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(bus.cpu_req && !m_busy() && !st));
        chk("underrun", 32'(underrun), 32'(m_under));
    endtask

    // One line: Hcnt 150..200 with h_tc on the last cycle. creq_mode 0/1 =
    // held low/high, 2 = random. rst_at pulses reset mid-cycle at that Hcnt.
    task automatic run_line(input int ack_pct, input int creq_mode, input int rst_at);
        for (int h = 150; h <= 200; h++) begin
            Hcnt        = 11'(h);
            h_tc        = (h == 200);
            bus.mem_ack = ($urandom_range(99) < ack_pct);
            bus.cpu_req = (creq_mode == 2) ? 1'($urandom_range(1)) : 1'(creq_mode);
            @(negedge clk);
            compare();
            req_at[h]  = bus.mem_req;
            addr_at[h] = bus.mem_addr;
            gnt_at[h]  = bus.cpu_gnt;
            if (h == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_async_mem_req", 32'(bus.mem_req), 0);
                chk("rst_async_Vcnt", 32'(Vcnt), 0);
                model_reset();
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                @(posedge clk);
                model_step();
                #1;
            end
        end
    endtask

    typedef struct {
        logic [10:0] hcnt;
        logic        creq;
        logic        e_hsync;
        logic        e_active;
        logic        e_gnt;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   v0, nreq;
        tbl[0] = '{11'd0,    1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{11'd159,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{11'd161,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{11'd175,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{11'd176,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{11'd191,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{11'd192,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{11'd2047, 1'b1, 1'b0, 1'b0, 1'b1};

        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        model_reset();

        // Held in reset: strobes decode Hcnt at Vcnt 0, port idle, CPU granted.
        for (int i = 0; i < 8; i++) begin
            Hcnt = tbl[i].hcnt;
            bus.cpu_req = tbl[i].creq;
            #3;
            chk("tbl_hsync", 32'(hsync), 32'(tbl[i].e_hsync));
            chk("tbl_active", 32'(active), 32'(tbl[i].e_active));
            chk("tbl_cpu_gnt", 32'(bus.cpu_gnt), 32'(tbl[i].e_gnt));
            chk("tbl_mem_req", 32'(bus.mem_req), 0);
            chk("tbl_Vcnt", 32'(Vcnt), 0);
            chk("tbl_frame_tc", 32'(frame_tc), 0);
            chk("tbl_vsync", 32'(vsync), 0);
            chk("tbl_underrun", 32'(underrun), 0);
        end

        @(posedge clk); #1;
        rst = 1'b0;

        // Full frame, always-ack, CPU asking throughout.
        for (int l = 0; l <= V_MX; l++) begin
            v0 = m_v;
            run_line(100, 1, -1);
            nreq = 0;
            for (int h = 150; h <= 200; h++) nreq += int'(req_at[h]);
            if (v0 == 5) begin
                for (int i = 0; i < 8; i++) begin
                    chk("l5_addr", 32'(addr_at[161 + i]), 48 + i);
                    chk("l5_req", 32'(req_at[161 + i]), 1);
                end
                chk("l5_done_req", 32'(req_at[169]), 0);
                chk("l5_gnt_before", 32'(gnt_at[159]), 1);
                chk("l5_gnt_start", 32'(gnt_at[160]), 0);
                chk("l5_gnt_done", 32'(gnt_at[169]), 0);
                chk("l5_gnt_back", 32'(gnt_at[170]), 1);
            end
            if (v0 == 239 || v0 == 250) chk("no_fetch_reqs", nreq, 0);
            if (v0 == 262) begin
                chk("l262_first_addr", 32'(addr_at[161]), 0);
                chk("l262_last_addr", 32'(addr_at[168]), 7);
                chk("l262_reqs", nreq, 8);
            end
        end
        chk("wrap_frame_tc", 32'(frame_tc), 1);
        chk("wrap_Vcnt", 32'(Vcnt), 0);

        // No acks across a line boundary.
        run_line(0, 0, -1);
        chk("stall_req_end", 32'(req_at[199]), 1);
        run_line(0, 0, -1);
`ifdef T03_FETCH_TIMEOUT_EN
        chk("tmo_req_dropped", 32'(req_at[150]), 0);
        chk("tmo_underrun", 32'(underrun), 1);
`else
        chk("stall_req_held", 32'(req_at[155]), 1);
        chk("stall_addr_held", 32'(addr_at[155]), 8);
        chk("stall_underrun", 32'(underrun), 0);
`endif

        // Reset while a stalled fetch is outstanding.
        rst = 1'b1;
        #1;
        chk("rst2_mem_req", 32'(bus.mem_req), 0);
        chk("rst2_underrun", 32'(underrun), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset at word 3 of line 4's fetch, then the next fetch starts fresh.
        for (int l = 0; l < 3; l++) run_line(100, 2, -1);
        run_line(100, 0, 164);
        chk("w3_addr", 32'(addr_at[164]), 35);
        run_line(100, 0, -1);
        chk("restart_idle", 32'(req_at[160]), 0);
        chk("restart_word0", 32'(addr_at[161]), 16);
        chk("restart_word7", 32'(addr_at[168]), 23);

        // Random acks and CPU requests over a whole frame.
        for (int l = 0; l <= V_MX; l++) run_line(60, 2, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/t03_scanline_scheduler.md
T03_SCANLINE_SCHEDULER -- requirements
Module: t03_scanline_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 11'd160: Hcnt value at which horizontal blanking starts.
REQ-002 SHALL have parameter HS_START, default 11'd176, and HS_END, default 11'd191: inclusive hsync window in Hcnt.
REQ-003 SHALL have parameter V_ACTIVE, default 10'd240, V_MAX, default 10'd262, and VS_LINE, default 10'd250: visible lines, last line index, and vsync line.
REQ-004 SHALL have parameter FETCH_WORDS, default 8: memory words fetched per line (power of two).
REQ-005 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, reset): one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports h_tc (in, 1, line-complete pulse) and Hcnt (in, 11, horizontal count), both from the horizontal counter.
REQ-007 SHALL have port Vcnt (out, 10, current line).
REQ-008 SHALL have ports hsync, vsync and active (out, 1 each, timing strobes).
REQ-009 SHALL have port frame_tc (out, 1, frame-complete pulse).
REQ-010 SHALL have ports mem_req (out, 1), mem_addr (out, 11) and mem_ack (in, 1): display fetch port.
REQ-011 SHALL have ports cpu_req (in, 1) and cpu_gnt (out, 1): CPU share of the memory port.
REQ-012 SHALL have port underrun (out, 1, sticky fetch-miss flag).

Function
REQ-013 Vcnt SHALL increment on each clk edge with h_tc=1, wrapping from V_MAX to 0.
REQ-014 frame_tc SHALL be registered: high for exactly one cycle following the edge on which Vcnt wraps to 0.
REQ-015 hsync SHALL be combinational: high iff HS_START<=Hcnt<=HS_END.
REQ-016 vsync SHALL be combinational: high iff Vcnt==VS_LINE.
REQ-017 active SHALL be combinational: high iff Hcnt<H_ACTIVE and Vcnt<V_ACTIVE.
REQ-018 next_line SHALL equal 0 when Vcnt==V_MAX, else Vcnt+1.
REQ-019 FSM states SHALL be IDLE, REQ, DONE.
REQ-020 IDLE->REQ SHALL occur when Hcnt==H_ACTIVE and next_line<V_ACTIVE; on entry the word counter SHALL clear to 0 and next_line SHALL be latched.
REQ-021 In REQ: mem_req=1 and mem_addr=latched_line*FETCH_WORDS+word, truncated to 11 bits.
REQ-022 On mem_ack=1 in REQ, word SHALL increment; the FSM SHALL go to DONE after word FETCH_WORDS-1 is acked.
REQ-023 DONE SHALL return to IDLE on the next cycle.
REQ-024 mem_ack SHALL be ignored outside REQ.
REQ-025 mem_req and mem_addr SHALL be held stable until acked.
REQ-026 cpu_gnt SHALL be combinational: cpu_req AND state==IDLE AND no IDLE->REQ transition this cycle.
REQ-027 Fetch start SHALL win over a simultaneous cpu_req.

Reset
REQ-028 rst SHALL asynchronously force Vcnt=0, frame_tc=0, state=IDLE, word=0, latched line=0 and underrun=0.
REQ-029 Consequently mem_req=0 and cpu_gnt follows cpu_req.
REQ-030 Reset mid-fetch SHALL drop mem_req immediately with no resume.

Configuration
REQ-031 With T03_FETCH_TIMEOUT_EN defined: h_tc=1 while state!=IDLE SHALL force IDLE next edge and set underrun=1 (sticky until rst).
REQ-032 Without T03_FETCH_TIMEOUT_EN: fetch SHALL continue across line boundaries until complete, and underrun SHALL be tied 0.

Verification
REQ-033 Reset then free-run with mem_ack=1 -> Vcnt 0..262 then 0, with frame_tc one cycle on wrap; hsync high Hcnt 176..191.
REQ-034 Vcnt=5, Hcnt reaches 160, mem_ack=1 every cycle -> mem_addr 48..55 on 8 consecutive cycles, then DONE, then IDLE.
REQ-035 Vcnt=239 or Vcnt=250 at Hcnt=160 -> no mem_req; Vcnt=262 at Hcnt=160 -> fetch of line 0, mem_addr 0..7.
REQ-036 cpu_req=1 held across Hcnt=160 -> cpu_gnt drops the same cycle the fetch starts, and returns the cycle after DONE.
REQ-037 With macro, mem_ack=0 through h_tc -> mem_req drops and underrun=1 sticky; without macro, mem_req persists and underrun=0.
REQ-038 rst pulse during REQ at word 3 -> mem_req=0 and Vcnt=0 asynchronously, and the next fetch restarts at word 0.
